// File: rtl/dft4_peak_detect.sv
// dft4_peak_detect
//   Takes one 4-bin complex DFT frame per handshake. Computes |X[k]|^2 for each
//   bin, one bin per clock, and picks the bin with the largest power. The
//   lowest index wins a tie. All results are published together and held
//   until the consumer accepts them.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   input frame handshake; in_ready is high only in IDLE
//   xr0..xr3, xi0..xi3    signed 16-bit real/imag parts of bins 0..3
//   out_valid / out_ready result handshake
//   power0..power3        unsigned 32-bit bin powers
//   peak_bin, peak_power  index and power of the largest bin
//   peak_flag             peak_power > PWR_THRESH
//   frame_cnt             completed result handshakes (wraps at 256)

// Squared magnitude of one complex sample. Each square is at most 2^30, so the
// sum is at most 2^31 and always fits in 32 unsigned bits.
module dft4_bin_power (
    input  logic signed [15:0] re,
    input  logic signed [15:0] im,
    output logic        [31:0] pwr
);
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;

    assign re_sq = re * re;
    assign im_sq = im * im;
    assign pwr   = $unsigned(re_sq) + $unsigned(im_sq);
endmodule

module dft4_peak_detect #(
    parameter logic [31:0] PWR_THRESH = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] xr0,
    input  logic [15:0] xr1,
    input  logic [15:0] xr2,
    input  logic [15:0] xr3,
    input  logic [15:0] xi0,
    input  logic [15:0] xi1,
    input  logic [15:0] xi2,
    input  logic [15:0] xi3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] power0,
    output logic [31:0] power1,
    output logic [31:0] power2,
    output logic [31:0] power3,
    output logic [1:0]  peak_bin,
    output logic [31:0] peak_power,
    output logic        peak_flag,
    output logic [7:0]  frame_cnt
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t state, state_nxt;

    logic [3:0][15:0] xr_r, xi_r;
    logic [1:0]       bin_idx;
    logic [31:0]      p0_r, p1_r, p2_r;   // bins 0..2 held until bin 3 completes
    logic [31:0]      run_pwr;
    logic [1:0]       run_bin;

    logic [31:0]      p_cur;
    logic             take_new;
    logic [31:0]      cand_pwr;
    logic [1:0]       cand_bin;
    logic             accept;

    dft4_bin_power u_pwr (
        .re  (xr_r[bin_idx]),
        .im  (xi_r[bin_idx]),
        .pwr (p_cur)
    );

    // Bin 0 always seeds the running peak. Later bins replace it only when they
    // are strictly greater, so a tie keeps the lower index.
    assign take_new = (bin_idx == 2'd0) || (p_cur > run_pwr);
    assign cand_pwr = take_new ? p_cur   : run_pwr;
    assign cand_bin = take_new ? bin_idx : run_bin;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)          state_nxt = CALC;
            CALC:    if (bin_idx == 2'd3)   state_nxt = HOLD;
            HOLD:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr_r       <= '0;
            xi_r       <= '0;
            bin_idx    <= 2'd0;
            p0_r       <= '0;
            p1_r       <= '0;
            p2_r       <= '0;
            run_pwr    <= '0;
            run_bin    <= 2'd0;
            out_valid  <= 1'b0;
            power0     <= '0;
            power1     <= '0;
            power2     <= '0;
            power3     <= '0;
            peak_bin   <= 2'd0;
            peak_power <= '0;
            peak_flag  <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            if (accept) begin
                xr_r    <= {xr3, xr2, xr1, xr0};
                xi_r    <= {xi3, xi2, xi1, xi0};
                bin_idx <= 2'd0;
            end

            if (state == CALC) begin
                bin_idx <= bin_idx + 2'd1;
                run_pwr <= cand_pwr;
                run_bin <= cand_bin;
                case (bin_idx)
                    2'd0: p0_r <= p_cur;
                    2'd1: p1_r <= p_cur;
                    2'd2: p2_r <= p_cur;
                    default: begin
                        // Last bin: every result field updates on this one edge.
                        power0     <= p0_r;
                        power1     <= p1_r;
                        power2     <= p2_r;
                        power3     <= p_cur;
                        peak_bin   <= cand_bin;
                        peak_power <= cand_pwr;
                        peak_flag  <= (cand_pwr > PWR_THRESH);
                        out_valid  <= 1'b1;
                    end
                endcase
            end

            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_dft4_peak_detect.sv
module tb_dft4_peak_detect;
    localparam logic [31:0] THRESH_T = 32'd10000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready;
    logic [3:0][15:0] cur_xr, cur_xi;

    logic        in_ready, out_valid, peak_flag;
    logic [31:0] power0, power1, power2, power3, peak_power;
    logic [1:0]  peak_bin;
    logic [7:0]  frame_cnt;

    logic        in_ready_t, out_valid_t, peak_flag_t;
    logic [31:0] power0_t, power1_t, power2_t, power3_t, peak_power_t;
    logic [1:0]  peak_bin_t;
    logic [7:0]  frame_cnt_t;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    dft4_peak_detect #(.PWR_THRESH(32'd0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .xr0(cur_xr[0]), .xr1(cur_xr[1]), .xr2(cur_xr[2]), .xr3(cur_xr[3]),
        .xi0(cur_xi[0]), .xi1(cur_xi[1]), .xi2(cur_xi[2]), .xi3(cur_xi[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .power0(power0), .power1(power1), .power2(power2), .power3(power3),
        .peak_bin(peak_bin), .peak_power(peak_power), .peak_flag(peak_flag),
        .frame_cnt(frame_cnt)
    );

    dft4_peak_detect #(.PWR_THRESH(THRESH_T)) dut_t (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
        .xr0(cur_xr[0]), .xr1(cur_xr[1]), .xr2(cur_xr[2]), .xr3(cur_xr[3]),
        .xi0(cur_xi[0]), .xi1(cur_xi[1]), .xi2(cur_xi[2]), .xi3(cur_xi[3]),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .power0(power0_t), .power1(power1_t), .power2(power2_t), .power3(power3_t),
        .peak_bin(peak_bin_t), .peak_power(peak_power_t), .peak_flag(peak_flag_t),
        .frame_cnt(frame_cnt_t)
    );

    // Reference: plain integer arithmetic on the frame, then a linear scan for
    // the first maximum.
    function automatic void model(input logic [3:0][15:0] xr, input logic [3:0][15:0] xi,
                                  input logic [31:0] th, output logic [3:0][31:0] pw,
                                  output logic [1:0] pb, output logic [31:0] pp, output logic pf);
        longint v;
        for (int k = 0; k < 4; k++) begin
            v = longint'($signed(xr[k])) * longint'($signed(xr[k]))
              + longint'($signed(xi[k])) * longint'($signed(xi[k]));
            pw[k] = v[31:0];
        end
        pb = 2'd0;
        pp = pw[0];
        for (int k = 1; k < 4; k++)
            if (pw[k] > pp) begin pp = pw[k]; pb = 2'(k); end
        pf = (pp > th);
    endfunction

    // Present a frame (caller guarantees IDLE), then count edges to out_valid.
    task automatic do_frame(input logic [3:0][15:0] xr, input logic [3:0][15:0] xi, output int lat);
        cur_xr = xr; cur_xi = xi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        cur_xr = {4{16'h1234}}; cur_xi = {4{16'h0101}};
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d exp 0", frame_cnt); end
        checks++; if ({power0, power1, power2, power3, peak_power} !== 160'd0)
            begin errors++; $display("FAIL rst_powers: got %h exp 0", {power0, power1, power2, power3, peak_power}); end
        checks++; if ({peak_bin, peak_flag} !== 3'd0) begin errors++; $display("FAIL rst_peak: got %b exp 0", {peak_bin, peak_flag}); end
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_no_capture: in_ready %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        int lat;
        do_frame({16'd0, 16'd0, 16'd0, 16'd100}, '0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d exp 4", lat); end
        checks++; if ({power0, power1, power2, power3} !== {32'd10000, 96'd0})
            begin errors++; $display("FAIL single_powers: got %0d %0d %0d %0d exp 10000 0 0 0", power0, power1, power2, power3); end
        checks++; if (peak_bin !== 2'd0 || peak_power !== 32'd10000)
            begin errors++; $display("FAIL single_peak: got bin %0d pwr %0d exp 0 10000", peak_bin, peak_power); end
        checks++; if (peak_flag_t !== 1'b0) begin errors++; $display("FAIL thresh_equal: flag %b exp 0", peak_flag_t); end
        release_out();
        checks++; if (out_valid !== 1'b0 || frame_cnt !== 8'(exp_cnt))
            begin errors++; $display("FAIL single_handshake: valid %b cnt %0d exp 0 %0d", out_valid, frame_cnt, exp_cnt); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (power0 !== 32'd10000 || peak_power !== 32'd10000)
            begin errors++; $display("FAIL single_hold_after: got %0d %0d exp 10000", power0, peak_power); end
    endtask

    task automatic test_ties();
        int lat;
        do_frame({-16'sd3, 16'sd0, 16'sd3, 16'sd0}, {16'sd4, 16'sd0, 16'sd4, 16'sd0}, lat);
        checks++; if ({power0, power1, power2, power3} !== {32'd0, 32'd25, 32'd0, 32'd25})
            begin errors++; $display("FAIL ties_powers: got %0d %0d %0d %0d exp 0 25 0 25", power0, power1, power2, power3); end
        checks++; if (peak_bin !== 2'd1 || peak_power !== 32'd25)
            begin errors++; $display("FAIL ties_peak: got bin %0d pwr %0d exp 1 25", peak_bin, peak_power); end
        release_out();
    endtask

    task automatic test_extremes();
        int lat;
        do_frame({16'd0, 16'd0, 16'h8000, 16'd0}, {16'd0, 16'd0, 16'h8000, 16'd0}, lat);
        checks++; if (power1 !== 32'h8000_0000) begin errors++; $display("FAIL ext_power1: got %h exp 80000000", power1); end
        checks++; if (peak_bin !== 2'd1 || peak_power !== 32'h8000_0000 || peak_flag !== 1'b1)
            begin errors++; $display("FAIL ext_peak: got bin %0d pwr %h flag %b exp 1 80000000 1", peak_bin, peak_power, peak_flag); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0][15:0] xr, xi;
        logic [3:0][31:0] pw; logic [1:0] pb; logic [31:0] pp; logic pf;
        xr = {16'd7, -16'sd200, 16'd30, 16'd5}; xi = {16'd1, 16'd9, -16'sd40, 16'd2};
        model(xr, xi, 32'd0, pw, pb, pp, pf);
        do_frame(xr, xi, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; cur_xr = {4{16'($urandom)}}; cur_xi = {4{16'($urandom)}};
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold_%0d: valid %b ready %b exp 1 0", i, out_valid, in_ready); end
            checks++; if ({power3, power2, power1, power0} !== pw || peak_bin !== pb || peak_power !== pp)
                begin errors++; $display("FAIL bp_stable_%0d: got %h bin %0d exp %h bin %0d", i, {power3, power2, power1, power0}, peak_bin, pw, pb); end
        end
        in_valid = 1'b1;
        release_out();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'(exp_cnt))
            begin errors++; $display("FAIL bp_release: valid %b ready %b cnt %0d exp 0 1 %0d", out_valid, in_ready, frame_cnt, exp_cnt); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || {power3, power2, power1, power0} !== pw)
            begin errors++; $display("FAIL bp_after: ready %b pw %h exp 1 %h", in_ready, {power3, power2, power1, power0}, pw); end
    endtask

    task automatic test_random();
        int lat;
        logic [3:0][15:0] xr, xi;
        logic [3:0][31:0] pw; logic [1:0] pb; logic [31:0] pp; logic pf;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 4; k++) begin
                xr[k] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                xi[k] = ($urandom_range(0, 3) == 0) ? xr[k] : 16'($urandom);
            end
            model(xr, xi, 32'd0, pw, pb, pp, pf);
            do_frame(xr, xi, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL rnd_latency_%0d: got %0d exp 4", n, lat); end
            checks++; if ({power3, power2, power1, power0} !== pw || peak_bin !== pb || peak_power !== pp || peak_flag !== pf)
                begin errors++; $display("FAIL rnd_result_%0d: got %h %0d %h %b exp %h %0d %h %b", n,
                      {power3, power2, power1, power0}, peak_bin, peak_power, peak_flag, pw, pb, pp, pf); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_out();
        end
    endtask

    task automatic test_reset_abort();
        in_valid = 1'b1; cur_xr = {16'd1, 16'd2, 16'd3, 16'd4}; cur_xi = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || frame_cnt !== 8'd0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL abort_ctrl: valid %b cnt %0d ready %b exp 0 0 1", out_valid, frame_cnt, in_ready); end
        checks++; if ({power0, power1, power2, power3, peak_power, peak_bin, peak_flag} !== 163'd0)
            begin errors++; $display("FAIL abort_results: got nonzero %h", {power0, power1, power2, power3, peak_power}); end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
                begin errors++; $display("FAIL abort_idle_%0d: valid %b ready %b exp 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [3:0][15:0] xr, xi;
        logic [3:0][31:0] pw; logic [1:0] pb; logic [31:0] pp; logic pf, pf_t;
        for (int n = 0; n < 256; n++) begin
            if (n == 0)      begin xr = {48'd0, 16'd100}; xi = '0; end
            else if (n == 1) begin xr = {48'd0, 16'd100}; xi = {48'd0, 16'd1}; end
            else for (int k = 0; k < 4; k++) begin xr[k] = 16'($urandom); xi[k] = 16'($urandom_range(0, 300)); end
            model(xr, xi, 32'd0, pw, pb, pp, pf);
            model(xr, xi, THRESH_T, pw, pb, pp, pf_t);
            do_frame(xr, xi, lat);
            checks++; if (lat !== 4 || {power3, power2, power1, power0} !== pw || peak_bin !== pb || peak_power !== pp || peak_flag !== pf)
                begin errors++; $display("FAIL b2b_result_%0d: lat %0d got %h %0d %b exp %h %0d %b", n, lat,
                      {power3, power2, power1, power0}, peak_bin, peak_flag, pw, pb, pf); end
            checks++; if (peak_flag_t !== pf_t || peak_power_t !== pp)
                begin errors++; $display("FAIL b2b_thresh_%0d: flag %b pwr %0d exp %b %0d", n, peak_flag_t, peak_power_t, pf_t, pp); end
            release_out();
            checks++; if (frame_cnt !== 8'(exp_cnt) || in_ready !== 1'b1)
                begin errors++; $display("FAIL b2b_cnt_%0d: cnt %0d ready %b exp %0d 1", n, frame_cnt, in_ready, exp_cnt); end
        end
        checks++; if (frame_cnt !== 8'd0 || frame_cnt_t !== 8'd0)
            begin errors++; $display("FAIL b2b_wrap: got %0d %0d exp 0", frame_cnt, frame_cnt_t); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ties();
        test_extremes();
        test_backpressure();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dft4_peak_detect.md
DFT4_PEAK_DETECT -- requirements
Module: dft4_peak_detect

Interface
REQ-001 SHALL have parameter: PWR_THRESH, 32'd0, peak_flag threshold on peak_power (unsigned, strict greater-than).
REQ-002 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  DFT frame present on xr*/xi*.
REQ-005 SHALL have port: in_ready  output  1  block can accept a frame.
REQ-006 SHALL have port: xr0..xr3  input  16 each  signed real part, bins 0..3.
REQ-007 SHALL have port: xi0..xi3  input  16 each  signed imaginary part, bins 0..3.
REQ-008 SHALL have port: out_valid  output  1  result frame present.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: power0..power3  output  32 each  unsigned |X[k]|^2.
REQ-011 SHALL have port: peak_bin  output  2  index of largest power.
REQ-012 SHALL have port: peak_power  output  32  unsigned power of peak_bin.
REQ-013 SHALL have port: peak_flag  output  1  peak_power > PWR_THRESH.
REQ-014 SHALL have port: frame_cnt  output  8  count of completed result handshakes.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, HOLD; reset state IDLE.
REQ-016 SHALL drive in_ready combinationally = (state==IDLE); in_valid outside IDLE is ignored.
REQ-017 SHALL, at the edge where in_valid && in_ready, register all eight inputs, clear bin index to 0, enter CALC.
REQ-018 SHALL, in CALC, compute one bin per cycle from registered inputs: p = xr*xr + xi*xi, full precision, unsigned 32 bits (max 2^31, no overflow, no saturation).
REQ-019 SHALL initialise the running peak with bin 0; later bins replace it only if strictly greater (ties keep lowest index).
REQ-020 SHALL complete bin 3 on the 4th CALC edge and, at that same edge, update power0..3, peak_bin, peak_power, peak_flag atomically, set out_valid=1, enter HOLD.
REQ-021 SHALL therefore assert out_valid exactly 4 clock edges after the input acceptance edge.
REQ-022 SHALL keep all result outputs stable while in HOLD with out_ready=0 (unbounded backpressure).
REQ-023 SHALL, at the edge where out_valid && out_ready, clear out_valid, increment frame_cnt (wrap 255->0), return to IDLE.
REQ-024 SHALL NOT accept a new frame in the result-handshake cycle; earliest next acceptance is the following edge (throughput 6 cycles/frame).
REQ-025 SHALL hold result outputs at last completed frame values after handshake until the next frame completes.
REQ-026 SHALL treat out_ready outside HOLD as don't-care.

Reset
REQ-027 SHALL, on reset assertion, immediately force state IDLE, out_valid=0, power0..3=0, peak_bin=0, peak_power=0, peak_flag=0, frame_cnt=0, internal registers 0.
REQ-028 SHALL abort any in-progress frame on reset (CALC or HOLD) with no partial result emitted.
REQ-029 SHALL show in_ready=1 during reset but SHALL NOT accept a frame while reset is high.

Verification
REQ-030 SHALL test: xr=(100,0,0,0), xi=0, accept at edge E -> out_valid at E+4, power0=10000, others 0, peak_bin=0, peak_power=10000.
REQ-031 SHALL test ties: xr=(0,3,0,-3), xi=(0,4,0,4) -> powers (0,25,0,25), peak_bin=1.
REQ-032 SHALL test extremes: xr1=xi1=-32768, others 0 -> power1=2147483648 (32'h8000_0000), peak_bin=1, peak_flag=1 (PWR_THRESH=0).
REQ-033 SHALL test backpressure: out_ready=0 for 10 cycles with in_valid pulsing -> outputs stable, in_ready=0, no capture; out_ready=1 -> out_valid=0 and in_ready=1 next cycle, frame_cnt+1.
REQ-034 SHALL test reset after 2 CALC cycles -> all outputs 0, frame_cnt=0, state IDLE, no out_valid pulse.
REQ-035 SHALL test 256 back-to-back frames -> frame_cnt wraps to 0; with PWR_THRESH=10000 and peak_power=10000 -> peak_flag=0, peak_power=10001 -> peak_flag=1.
